// File: rtl/fifo_panel_test.sv
// FIFO exercise panel: debounced buttons drive write/read/clear on a small register FIFO,
// and a multiplexed seven-segment display shows the last read word and the occupancy.
module fifo_panel_test #(
  parameter int unsigned WL             = 4,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned DBNC_CYCLES    = 1_000_000,
  parameter int unsigned REFRESH_CYCLES = 100_000,
  parameter int unsigned TICK_CYCLES    = 50_000_000
) (
  input  logic          CLK_IN,
  input  logic          RST_N,
  input  logic [WL-1:0] sw,
  input  logic          btn_wr,
  input  logic          btn_rd,
  input  logic          btn_clr,
  output logic [3:0]    anode,
  output logic [6:0]    BCD_out,
  output logic          dp,
  output logic          full,
  output logic          empty,
  output logic          error,
  output logic          seconds
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned OW  = AW + 1;
  localparam int unsigned DCW = $clog2(DBNC_CYCLES + 1);
  localparam int unsigned RCW = $clog2(REFRESH_CYCLES + 1);
  localparam int unsigned TCW = $clog2(TICK_CYCLES + 1);

  localparam logic [DCW-1:0] DbncLast = DCW'(DBNC_CYCLES - 1);
  localparam logic [RCW-1:0] RefLast  = RCW'(REFRESH_CYCLES - 1);
  localparam logic [TCW-1:0] TickLast = TCW'(TICK_CYCLES - 1);
  localparam logic [OW-1:0]  OccFull  = OW'(DEPTH);
  localparam bit             HiBlank  = (WL <= 4);

  // Button order in the vectors below: 0 = write, 1 = read, 2 = clear.
  logic [2:0]          sync1_q, sync2_q, db_q, db_d, db_dly_q;
  logic [2:0][DCW-1:0] cnt_q, cnt_d;
  logic                wr_p, rd_p, clr_p;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DbncLast) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign wr_p  = db_q[0] & ~db_dly_q[0];
  assign rd_p  = db_q[1] & ~db_dly_q[1];
  assign clr_p = db_q[2] & ~db_dly_q[2];

  logic [WL-1:0] mem_q [DEPTH];
  logic [WL-1:0] sw_q, dout_q, dout_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          err_q, err_d, do_wr, do_rd, is_full, is_empty;

  assign is_full  = (occ_q == OccFull);
  assign is_empty = (occ_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    err_d    = err_q;
    dout_d   = dout_q;
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    if (clr_p) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      err_d    = 1'b0;
    end else begin
      if (wr_p && rd_p) begin
        // A simultaneous pair on a full FIFO is legal: the read frees the slot being written.
        do_wr = 1'b1;
        if (is_empty) err_d = 1'b1;
        else          do_rd = 1'b1;
      end else if (wr_p) begin
        if (is_full) err_d = 1'b1;
        else         do_wr = 1'b1;
      end else if (rd_p) begin
        if (is_empty) err_d = 1'b1;
        else          do_rd = 1'b1;
      end
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = mem_q[rd_ptr_q];
      end
      if (do_wr && !do_rd)      occ_d = occ_q + 1'b1;
      else if (do_rd && !do_wr) occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (do_wr) mem_q[wr_ptr_q] <= sw_q;
  end

  logic [RCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]     digit_q, digit_d;
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic           seconds_q, seconds_d;

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_cnt_q == RefLast) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 1'b1;
    end
    tick_cnt_d = tick_cnt_q + 1'b1;
    seconds_d  = seconds_q;
    if (tick_cnt_q == TickLast) begin
      tick_cnt_d = '0;
      seconds_d  = ~seconds_q;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_dly_q   <= '0;
      cnt_q      <= '0;
      sw_q       <= '0;
      dout_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      err_q      <= 1'b0;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      tick_cnt_q <= '0;
      seconds_q  <= 1'b0;
    end else begin
      sync1_q    <= {btn_clr, btn_rd, btn_wr};
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_dly_q   <= db_q;
      cnt_q      <= cnt_d;
      sw_q       <= sw;
      dout_q     <= dout_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      tick_cnt_q <= tick_cnt_d;
      seconds_q  <= seconds_d;
    end
  end

  logic [7:0] dout_ext;
  logic [3:0] nib;
  logic [6:0] seg;
  logic       blank;

  assign dout_ext = 8'(dout_q);

  always_comb begin
    anode = 4'b1110;
    nib   = dout_ext[3:0];
    blank = 1'b0;
    unique case (digit_q)
      2'd0: begin
        anode = 4'b1110;
        nib   = dout_ext[3:0];
      end
      2'd1: begin
        anode = 4'b1101;
        nib   = dout_ext[7:4];
        blank = HiBlank;
      end
      2'd2: begin
        anode = 4'b1011;
        blank = 1'b1;
      end
      2'd3: begin
        anode = 4'b0111;
        nib   = 4'(occ_q);
      end
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

  assign BCD_out = blank ? 7'b1111111 : seg;
  assign dp      = ~((digit_q == 2'd3) && err_q);
  assign full    = is_full;
  assign empty   = is_empty;
  assign error   = err_q;
  assign seconds = seconds_q;

endmodule
